// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

    localparam int PC_W_DEF = 8;

    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JC   = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Loads and stores skip the flag update and go through MEM.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive cycles a memory request waits for its ack and flags
// the cycle on which the wait budget is used up.
module seq_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // The TIMEOUT-th un-acked request cycle is the last one; an ack in that
    // cycle drops 'waiting' and therefore wins over the timeout.
    assign expired = waiting && (count == CW'(TIMEOUT - 1));

    // Count waiting cycles; restart whenever the wait ends or the FSM leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || !waiting || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetches instructions, updates PC, owns the
// status register and sequences data-memory access and write-back.
//
// Handshake (imem and dmem alike): req is a registered output that rises on
// entry to the requesting state and stays high until the cycle in which ack
// is sampled high; ack may arrive in the first req cycle, and ack while req
// is low is ignored.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int PC_RESET = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic [3:0]      alu_flags,
    output logic [15:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      sr,
    output logic            rf_we,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output state_t          fsm_state
);

    state_t          state;
    state_t          state_next;
    logic [3:0]      opcode;
    logic [PC_W-1:0] jump_target;
    logic            waiting;
    logic            timer_clear;
    logic            timed_out;

    assign opcode      = ir[3:0];
    assign jump_target = PC_W'(ir[11:4]);
    assign imem_addr   = pc;
    assign fsm_state   = state;

    assign waiting     = ((state == S_FETCH) && !imem_ack) ||
                         ((state == S_MEM) && !dmem_ack);
    assign timer_clear = !((state == S_FETCH) || (state == S_MEM));

    seq_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .waiting(waiting),
        .expired(timed_out)
    );

    // Next-state selection from the current state, opcode and acks.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack)       state_next = S_DECODE;
                else if (timed_out) state_next = S_HALT;
            end
            S_DECODE: begin
                if (opcode == OP_JMP || opcode == OP_JC) state_next = S_FETCH;
                else if (opcode == OP_HALT)              state_next = S_HALT;
                else                                     state_next = S_EXEC;
            end
            S_EXEC:   state_next = is_mem_op(opcode) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack)       state_next = (opcode == OP_SW) ? S_FETCH : S_WB;
                else if (timed_out) state_next = S_HALT;
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // State, registered outputs (decoded from the next state) and datapath regs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= PC_W'(PC_RESET);
            ir       <= '0;
            sr       <= '0;
            err      <= 1'b0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next == S_FETCH);
            dmem_req <= (state_next == S_MEM);
            dmem_we  <= (state_next == S_MEM) && (opcode == OP_SW);
            rf_we    <= (state_next == S_WB);
            busy     <= !((state_next == S_IDLE) || (state_next == S_HALT));
            halted   <= (state_next == S_HALT);
            if (timed_out) err <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    if ((opcode == OP_JMP) || ((opcode == OP_JC) && (sr != 4'd0)))
                        pc <= jump_target;
                end
                S_EXEC: begin
                    if (!is_mem_op(opcode)) sr <= alu_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level model expanded into a
// per-cycle expected trace, plus literal checks on final state.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 99;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic [3:0]  alu_flags = 4'h0;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [3:0]  sr;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic        err;
    state_t      fsm_state;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W    (8),
        .PC_RESET(0),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .alu_flags (alu_flags),
        .ir        (ir),
        .pc        (pc),
        .sr        (sr),
        .rf_we     (rf_we),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // ---------------- trace record / scoreboard ----------------
    typedef struct packed {
        logic        imem_req;
        logic [7:0]  imem_addr;
        logic        dmem_req;
        logic        dmem_we;
        logic        rf_we;
        logic        busy;
        logic        halted;
        logic        err;
        logic [15:0] ir;
        logic [7:0]  pc;
        logic [3:0]  sr;
    } obs_t;

    localparam int OBS_W = $bits(obs_t);
    logic [OBS_W-1:0] exp_q[$];

    int checks = 0;
    int failures = 0;

    // ---------------- program tables ----------------
    logic [15:0] prog_instr[16];
    int          prog_fw[16];
    logic [3:0]  prog_flags[16];
    int          prog_dw[16];
    int          prog_n = 0;

    task automatic set_instr(input int i, input logic [15:0] instr, input int fw,
                             input logic [3:0] flags, input int dw);
        prog_instr[i] = instr;
        prog_fw[i]    = fw;
        prog_flags[i] = flags;
        prog_dw[i]    = dw;
    endtask

    // ---------------- memory responders ----------------
    int pidx = 0;
    int icnt = 0;
    int dcnt = 0;
    int cur_dw = 0;

    always @(negedge clk) begin
        if (!rst) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            pidx = 0;
            icnt = 0;
            dcnt = 0;
        end else begin
            imem_ack = 1'b0;
            if (imem_req) begin
                if (pidx < prog_n && icnt == prog_fw[pidx]) begin
                    imem_ack   = 1'b1;
                    imem_rdata = prog_instr[pidx];
                    alu_flags  = prog_flags[pidx];
                    cur_dw     = prog_dw[pidx];
                    pidx++;
                    icnt = 0;
                end else begin
                    icnt++;
                end
            end else begin
                icnt = 0;
            end
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (dcnt == cur_dw) begin
                    dmem_ack = 1'b1;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    task automatic push_rec(input logic req, input logic dreq, input logic dwe,
                            input logic rfwe, input logic bsy, input logic hlt,
                            input logic er, input logic [15:0] ir_e,
                            input logic [7:0] pc_e, input logic [3:0] sr_e);
        obs_t r;
        r.imem_req  = req;
        r.imem_addr = pc_e;
        r.dmem_req  = dreq;
        r.dmem_we   = dwe;
        r.rf_we     = rfwe;
        r.busy      = bsy;
        r.halted    = hlt;
        r.err       = er;
        r.ir        = ir_e;
        r.pc        = pc_e;
        r.sr        = sr_e;
        exp_q.push_back(r);
    endtask

    // One record per cycle, starting with the first cycle after start.
    task automatic build_model();
        logic [7:0]  m_pc;
        logic [15:0] m_ir;
        logic [3:0]  m_sr;
        logic [3:0]  op;
        m_pc = 8'h00;
        m_ir = 16'h0000;
        m_sr = 4'h0;
        exp_q.delete();
        for (int i = 0; i < prog_n; i++) begin
            if (prog_fw[i] >= TIMEOUT) begin
                repeat (TIMEOUT) push_rec(1, 0, 0, 0, 1, 0, 0, m_ir, m_pc, m_sr);
                repeat (4) push_rec(0, 0, 0, 0, 0, 1, 1, m_ir, m_pc, m_sr);
                return;
            end
            repeat (prog_fw[i] + 1) push_rec(1, 0, 0, 0, 1, 0, 0, m_ir, m_pc, m_sr);
            m_ir = prog_instr[i];
            m_pc = m_pc + 8'd1;
            push_rec(0, 0, 0, 0, 1, 0, 0, m_ir, m_pc, m_sr);
            op = m_ir[3:0];
            if (op == 4'd9) begin
                m_pc = m_ir[11:4];
            end else if (op == 4'd14) begin
                if (m_sr != 4'd0) m_pc = m_ir[11:4];
            end else if (op == 4'd15) begin
                repeat (4) push_rec(0, 0, 0, 0, 0, 1, 0, m_ir, m_pc, m_sr);
                return;
            end else if (op == 4'd7 || op == 4'd8) begin
                push_rec(0, 0, 0, 0, 1, 0, 0, m_ir, m_pc, m_sr);
                repeat (prog_dw[i] + 1)
                    push_rec(0, 1, (op == 4'd8), 0, 1, 0, 0, m_ir, m_pc, m_sr);
                if (op == 4'd7) push_rec(0, 0, 0, 1, 1, 0, 0, m_ir, m_pc, m_sr);
            end else begin
                push_rec(0, 0, 0, 0, 1, 0, 0, m_ir, m_pc, m_sr);
                m_sr = prog_flags[i];
                push_rec(0, 0, 0, 1, 1, 0, 0, m_ir, m_pc, m_sr);
            end
        end
    endtask

    // ---------------- compare process ----------------
    logic checking = 1'b0;
    int   cyc = 0;
    int   n_ireq = 0;
    int   n_dreq = 0;
    int   n_dwe = 0;
    int   n_rfwe = 0;
    obs_t cmp_e;
    obs_t cmp_a;

    function automatic string fmt_obs(input obs_t o);
        return $sformatf("req=%b addr=%h dreq=%b dwe=%b rfwe=%b busy=%b halt=%b err=%b ir=%h pc=%h sr=%b",
                         o.imem_req, o.imem_addr, o.dmem_req, o.dmem_we, o.rf_we,
                         o.busy, o.halted, o.err, o.ir, o.pc, o.sr);
    endfunction

    always @(negedge clk) begin
        if (checking && exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_a.imem_req  = imem_req;
            cmp_a.imem_addr = imem_addr;
            cmp_a.dmem_req  = dmem_req;
            cmp_a.dmem_we   = dmem_req ? dmem_we : 1'b0;
            cmp_a.rf_we     = rf_we;
            cmp_a.busy      = busy;
            cmp_a.halted    = halted;
            cmp_a.err       = err;
            cmp_a.ir        = ir;
            cmp_a.pc        = pc;
            cmp_a.sr        = sr;
            if (!cmp_e.dmem_req) cmp_e.dmem_we = 1'b0;
            checks++;
            if (cmp_a !== cmp_e) begin
                failures++;
                $display("FAIL trace cyc=%0d actual {%s} expected {%s}",
                         cyc, fmt_obs(cmp_a), fmt_obs(cmp_e));
            end
            if (imem_req) n_ireq++;
            if (dmem_req) n_dreq++;
            if (dmem_req && dmem_we) n_dwe++;
            if (rf_we) n_rfwe++;
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        checking = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_state"}, fsm_state, S_IDLE);
        check_val({tag, "_pc"}, pc, 8'h00);
        check_val({tag, "_ir"}, ir, 16'h0000);
        check_val({tag, "_sr"}, sr, 4'h0);
        check_val({tag, "_err"}, err, 1'b0);
        check_val({tag, "_outs"}, {imem_req, dmem_req, rf_we, busy, halted}, 5'b0);
    endtask

    task automatic run_program(input bit hold_start);
        n_ireq = 0;
        n_dreq = 0;
        n_dwe = 0;
        n_rfwe = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        checking = 1'b1;
        for (int k = 0; k < 500 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checking = 1'b0;
        start = 1'b0;
        check_val("trace_drained", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    obs_t pin;

    initial begin
        // Reset held low from time 0.
        #12;
        check_reset_state("rst_low");
        do_reset();
        @(negedge clk);
        check_reset_state("rst_released");

        // Run A: ALU, ALU, jump, cond-jump not taken, I-type ALU,
        // cond-jump taken, delayed load, halt. start held high throughout.
        set_instr(0, 16'h0001, 0, 4'b0001, 0);
        set_instr(1, 16'h0002, 2, 4'b0000, 0);
        set_instr(2, 16'h0A59, 0, 4'b0000, 0);
        set_instr(3, 16'h033E, 1, 4'b0000, 0);
        set_instr(4, 16'h0005, 0, 4'b0100, 0);
        set_instr(5, 16'h033E, 0, 4'b0000, 0);
        set_instr(6, 16'h0007, 0, 4'b1111, 3);
        set_instr(7, 16'h000F, 0, 4'b0000, 0);
        prog_n = 8;
        build_model();
        pin = exp_q[3];
        check_val("model_wb_cycle4_rfwe", pin.rf_we, 1'b1);
        check_val("model_wb_cycle4_sr", pin.sr, 4'b0001);
        pin = exp_q[4];
        check_val("model_fetch_cycle5", {pin.imem_req, pin.pc}, {1'b1, 8'h01});
        run_program(1'b1);
        check_val("runA_pc", pc, 8'h35);
        check_val("runA_sr", sr, 4'b0100);
        check_val("runA_ir", ir, 16'h000F);
        check_val("runA_halt", {halted, busy, err}, 3'b100);
        check_val("runA_dmem_req_cycles", n_dreq, 4);
        check_val("runA_dmem_we_cycles", n_dwe, 0);
        check_val("runA_rf_we_pulses", n_rfwe, 4);

        // Run B: jump to FF, store at FF (pc wraps), halt fetched from 00.
        do_reset();
        set_instr(0, 16'h0FF9, 0, 4'b0000, 0);
        set_instr(1, 16'h0008, 0, 4'b1010, 1);
        set_instr(2, 16'h000F, 0, 4'b0000, 0);
        prog_n = 3;
        build_model();
        run_program(1'b0);
        check_val("runB_pc_wrapped", pc, 8'h01);
        check_val("runB_dmem_we_cycles", n_dwe, 2);
        check_val("runB_rf_we_pulses", n_rfwe, 0);
        check_val("runB_sr", sr, 4'h0);
        check_val("runB_halted", halted, 1'b1);

        // Run C: fetch never acknowledged -> timeout halt with err.
        do_reset();
        set_instr(0, 16'h0001, NEVER, 4'b0000, 0);
        prog_n = 1;
        build_model();
        run_program(1'b0);
        check_val("runC_req_cycles", n_ireq, TIMEOUT);
        check_val("runC_err_halt", {err, halted, imem_req}, 3'b110);

        // Reset clears the sticky error.
        do_reset();
        @(negedge clk);
        check_reset_state("after_timeout");

        // Run D: reset asserted mid-FETCH drops the request at once.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("runD_req_before", imem_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_val("runD_req_dropped", imem_req, 1'b0);
        check_val("runD_state_idle", fsm_state, S_IDLE);
        check_val("runD_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM that sequences the 16-bit datapath.
- Fetches instructions over a req/ack port, holds the instruction register that drives the decoder, and updates PC (including jumps and conditional jumps).
- Owns the 4-bit status register SR; sequences data-memory access and register-file write-back.
- Sits between instruction/data memories and the decode/ALU/register-file datapath.

Parameters:
- PC_W, 8: PC / jump-address width; matches the 8-bit jump field ir[11:4].
- PC_RESET, 0: PC value after reset.
- TIMEOUT, 15: max cycles to wait for imem_ack/dmem_ack before the error halt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching at current PC.
- imem_req  out  1  instruction fetch request; held high until imem_ack.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  16  fetched instruction.
- dmem_req  out  1  data access request; held until dmem_ack.
- dmem_we  out  1  1 = store (opcode 8), 0 = load (opcode 7); valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- alu_flags  in  4  ALU flags {V,C,N,Z}, sampled in EXEC.
- ir  out  16  instruction register, fed to the decoder.
- pc  out  PC_W  program counter.
- sr  out  4  status register.
- rf_we  out  1  register-file write strobe, one cycle in WB.
- busy  out  1  high in any state other than IDLE and HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky; set when an ack times out.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, pc = PC_RESET.
  - ir, sr, err, wait counter = 0.
  - All request and strobe outputs = 0, including a request raised mid-handshake.
- Opcode field is ir[3:0]:
  - 7 = load, 8 = store.
  - 9 = jump (target ir[11:4]).
  - 14 = conditional jump, taken iff sr != 0.
  - 15 = halt.
  - All others are ALU ops (R-type, plus I-type 5 and 6).
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start = 1 → FETCH. start in any other state is ignored.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: ir <= imem_rdata; pc <= pc + 1, wrapping 2^PC_W-1 → 0; → DECODE.
  - An ack in the same cycle as the first req-high cycle is legal (minimum 1 cycle).
- DECODE (1 cycle):
  - 9: pc <= ir[11:4]; → FETCH.
  - 14: if sr != 0 then pc <= ir[11:4]; → FETCH either way.
  - 15: → HALT.
  - Otherwise → EXEC.
- EXEC (1 cycle):
  - ALU ops: sr <= alu_flags; → WB.
  - 7/8: sr unchanged; → MEM.
- MEM:
  - dmem_req = 1; dmem_we = (opcode == 8).
  - On dmem_ack: load → WB; store → FETCH.
- WB: rf_we = 1 for exactly one cycle; → FETCH.
- HALT: absorbing; exit only via reset. halted = 1, busy = 0.
- Acks are ignored when the matching req is low.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle req is high without ack.
  - When it reaches TIMEOUT: err <= 1, req drops next cycle, → HALT.
  - An ack arriving on the same cycle as the timeout wins; no error.
- Latency with zero-wait memories, counted from entering FETCH to the next FETCH entry:
  - jump / conditional jump: 2 cycles.
  - store: 4 cycles.
  - ALU op: 4 cycles.
  - load: 5 cycles.
- sr and ir change only at the points listed above; they are stable in all other cycles.
- One-hot or binary state encoding is acceptable. All outputs are registered, or decoded from state alone (no input→output combinational path).

Decomposition:
- Package seq_pkg holds:
  - state enumeration.
  - opcode constants OP_LW = 7, OP_SW = 8, OP_JMP = 9, OP_JC = 14, OP_HALT = 15.
  - PC_W default.
- One natural sub-module, seq_wait_timer: wait counter with clear/enable/timeout, instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset then start, imem returns 16'h0001 (R-type op 1) with zero wait, alu_flags = 4'b0001 → rf_we pulses on cycle 4, sr = 4'b0001, pc = 1, next FETCH at cycle 5.
- ir = 16'h0A59 (jump, ir[11:4] = 8'hA5) → pc = 8'hA5 two cycles after FETCH ack; no rf_we, no dmem_req.
- Conditional jump 16'h033E, tested twice:
  - sr = 0 → pc = old+1.
  - sr = 4'b0100 → pc = 8'h33.
- Load (opcode 7) with dmem_ack delayed 3 cycles:
  - dmem_req high 4 cycles with dmem_we = 0.
  - rf_we pulses the cycle after the ack.
  - sr unchanged.
- Store (opcode 8) at pc = 8'hFF: dmem_we = 1, no rf_we, pc wraps to 8'h00.
- imem_ack never asserted:
  - err = 1 and halted = 1 after 15 cycles of req.
  - Then assert rst low mid-FETCH on a second run → imem_req drops immediately, state IDLE.
